// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB read/write master.
//   sccb_state_t   : controller states (one bus segment per state visit)
//   SCCB_OP_*      : operation select carried by i_rw
//   SCCB_DEFAULT_ID: OV7670 write address (7-bit ID plus R/W bit)
//   sccb_quarter_t : quarter-phase index q0..q3 inside a bus segment
package sccb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SEND,
    ST_ACK,
    ST_RECV,
    ST_NACK,
    ST_STOP,
    ST_DONE
  } sccb_state_t;

  localparam logic SCCB_OP_WRITE = 1'b0;
  localparam logic SCCB_OP_READ  = 1'b1;

  localparam logic [7:0] SCCB_DEFAULT_ID = 8'h42;

  typedef logic [1:0] sccb_quarter_t;
  localparam sccb_quarter_t Q0 = 2'd0;
  localparam sccb_quarter_t Q1 = 2'd1;
  localparam sccb_quarter_t Q2 = 2'd2;
  localparam sccb_quarter_t Q3 = 2'd3;

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-phase timebase for the SCCB master.
//   clk, rst_n : system clock, asynchronous active-low reset
//   i_en       : run enable; while low the counter and quarter index are held at 0
//   o_tick     : one-clk pulse marking the last clk of the current quarter
//   o_q        : index of the current quarter (q0..q3), advances after each tick
module sccb_tick_gen
  import sccb_pkg::*;
#(
  parameter int QUARTER = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  output logic       o_tick,
  output logic [1:0] o_q
);

  localparam int CW = (QUARTER > 1) ? $clog2(QUARTER) : 1;

  logic [CW-1:0] cnt;
  logic          at_end;

  assign at_end = (cnt == CW'(QUARTER - 1));
  assign o_tick = i_en && at_end;

  // NOTE: state registers take non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      o_q <= Q0;
    end else if (!i_en) begin
      // Holding at zero while idle makes the first quarter after accept
      // exactly QUARTER clks long.
      cnt <= '0;
      o_q <= Q0;
    end else if (at_end) begin
      cnt <= '0;
      o_q <= o_q + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sccb_master_rw.sv
// SCCB (OV7670-class) master with 3-phase writes and 2-phase reads.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   i_start      : request, sampled only when idle
//   i_rw         : 0 = write, 1 = write sub-address then read one byte
//   i_reg_addr   : register sub-address
//   i_wdata      : write data (ignored for reads)
//   o_busy       : high from accept until o_done
//   o_done       : one-clk pulse ending every transaction, aborted or not
//   o_ack_error  : sticky slave-NACK flag, cleared on the next accept
//   o_rdata      : last successfully read byte
//   o_sio_c      : SCCB clock
//   io_sio_d     : SCCB data, driven or released to high-Z
module sccb_master_rw
  import sccb_pkg::*;
#(
  parameter int         SYS_CLK_HZ  = 100_000_000,
  parameter int         SCCB_CLK_HZ = 100_000,
  parameter logic [7:0] DEV_ID      = SCCB_DEFAULT_ID,
  parameter bit         ACK_CHECK   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_rw,
  input  logic [7:0] i_reg_addr,
  input  logic [7:0] i_wdata,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ack_error,
  output logic [7:0] o_rdata,
  output logic       o_sio_c,
  inout  wire        io_sio_d
);

  localparam int QUARTER = SYS_CLK_HZ / (4 * SCCB_CLK_HZ);

  generate
    if (QUARTER < 1) begin : g_bad_quarter
      $error("sccb_master_rw: SYS_CLK_HZ too low for SCCB_CLK_HZ (QUARTER < 1)");
    end
  endgenerate

  sccb_state_t   state, state_n;
  sccb_quarter_t q;
  logic          tick;
  logic          seg_end;
  logic          sample;
  logic          accept;

  logic          op_q;
  logic [7:0]    reg_addr_q;
  logic [7:0]    wdata_q;
  logic [1:0]    phase;     // index of the master-written byte in flight
  logic [2:0]    bit_cnt;
  logic          ack_bad;
  logic [7:0]    rx_shift;
  logic [7:0]    tx_byte;
  logic          sda_in;

  logic          sio_c_n, sio_d_n, sio_oe_n;
  logic          sio_c_q, sio_d_q, sio_oe_q;

  assign o_busy  = (state != ST_IDLE) && (state != ST_DONE);
  assign o_done  = (state == ST_DONE);
  assign accept  = (state == ST_IDLE) && i_start;
  assign seg_end = tick && (q == Q3);
  assign sample  = tick && (q == Q2);
  assign sda_in  = io_sio_d;

  sccb_tick_gen #(
    .QUARTER (QUARTER)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (o_busy),
    .o_tick (tick),
    .o_q    (q)
  );

  // Byte on the wire for the current phase; the second ID of a read carries
  // the read bit.
  always_comb begin
    tx_byte = DEV_ID;
    case (phase)
      2'd0:    tx_byte = DEV_ID;
      2'd1:    tx_byte = reg_addr_q;
      default: tx_byte = (op_q == SCCB_OP_READ) ? (DEV_ID | 8'h01) : wdata_q;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (i_start) state_n = ST_START;
      ST_START: if (seg_end) state_n = ST_SEND;
      ST_SEND:  if (seg_end && bit_cnt == 3'd7) state_n = ST_ACK;
      ST_ACK: begin
        if (seg_end) begin
          if (ACK_CHECK && ack_bad)         state_n = ST_STOP;
          else if (op_q == SCCB_OP_WRITE)   state_n = (phase == 2'd2) ? ST_STOP : ST_SEND;
          else if (phase == 2'd1)           state_n = ST_STOP;
          else if (phase == 2'd2)           state_n = ST_RECV;
          else                              state_n = ST_SEND;
        end
      end
      ST_RECV:  if (seg_end && bit_cnt == 3'd7) state_n = ST_NACK;
      ST_NACK:  if (seg_end) state_n = ST_STOP;
      ST_STOP: begin
        // phase reaches 2 at this point only after the sub-address phase of
        // a read that was not aborted: issue the repeated start.
        if (seg_end)
          state_n = (op_q == SCCB_OP_READ && phase == 2'd2 && !o_ack_error)
                    ? ST_START : ST_DONE;
      end
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Bus levels for the current segment and quarter.
  always_comb begin
    sio_c_n  = 1'b1;
    sio_d_n  = 1'b1;
    sio_oe_n = 1'b1;
    case (state)
      ST_START: sio_d_n = (q == Q0 || q == Q1);
      ST_SEND: begin
        sio_c_n = (q == Q2 || q == Q3);
        sio_d_n = tx_byte[3'd7 - bit_cnt];
      end
      ST_ACK, ST_RECV: begin
        sio_c_n  = (q == Q2 || q == Q3);
        sio_oe_n = 1'b0;
      end
      ST_NACK:  sio_c_n = (q == Q2 || q == Q3);
      ST_STOP: begin
        sio_c_n = (q != Q0);
        sio_d_n = (q == Q2 || q == Q3);
      end
      default: begin
        sio_c_n  = 1'b1;
        sio_d_n  = 1'b1;
        sio_oe_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op_q        <= SCCB_OP_WRITE;
      reg_addr_q  <= '0;
      wdata_q     <= '0;
      phase       <= '0;
      bit_cnt     <= '0;
      ack_bad     <= 1'b0;
      rx_shift    <= '0;
      o_ack_error <= 1'b0;
      o_rdata     <= '0;
      sio_c_q     <= 1'b1;
      sio_d_q     <= 1'b1;
      sio_oe_q    <= 1'b1;
    end else begin
      state    <= state_n;
      // Pins are registered so the bus never sees decode glitches.
      sio_c_q  <= sio_c_n;
      sio_d_q  <= sio_d_n;
      sio_oe_q <= sio_oe_n;

      if (accept) begin
        op_q        <= i_rw;
        reg_addr_q  <= i_reg_addr;
        wdata_q     <= i_wdata;
        o_ack_error <= 1'b0;
        phase       <= '0;
        bit_cnt     <= '0;
      end

      if (sample) begin
        if (state == ST_ACK)  ack_bad  <= sda_in;
        if (state == ST_RECV) rx_shift <= {rx_shift[6:0], sda_in};
      end

      if (seg_end) begin
        case (state)
          ST_SEND, ST_RECV: bit_cnt <= bit_cnt + 3'd1;
          ST_ACK: begin
            phase <= phase + 2'd1;
            if (ACK_CHECK && ack_bad) o_ack_error <= 1'b1;
          end
          default: ;
        endcase
      end

      // Load on the edge entering DONE so o_rdata is already valid while
      // o_done is high.
      if (state == ST_STOP && state_n == ST_DONE &&
          op_q == SCCB_OP_READ && !o_ack_error)
        o_rdata <= rx_shift;
    end
  end

  assign o_sio_c  = sio_c_q;
  assign io_sio_d = sio_oe_q ? sio_d_q : 1'bz;

endmodule
